// File: rtl/jtag_host.sv
// Bit-level JTAG initiator: divides clk into TCK and runs TAP reset, IR scan or DR scan
// commands, each starting and ending in Run-Test/Idle, capturing tdo during the shift.
module jtag_host #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trst,
   input  logic               tdo
);

   localparam int SW = (LEN_W > 3) ? LEN_W : 3;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RESP} state_t;
   typedef enum logic [1:0] {OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2} op_t;

   state_t             state, nxt_state;
   op_t                op_r;
   logic [LEN_W-1:0]   len_r;
   logic [MAX_LEN-1:0] data_r;
   logic [SW-1:0]      step, nxt_step, pre_last, post_last, len_ext;
   logic [CW-1:0]      div_cnt;
   logic               nxt_tms, nxt_tdi, nxt_trst;
   logic               is_reset, tick;

   assign is_reset  = (op_r == OP_RESET);
   assign tick      = (div_cnt == CW'(CLK_DIV - 1));
   assign len_ext   = SW'(len_r);
   assign pre_last  = is_reset ? SW'(4) : ((op_r == OP_IR) ? SW'(3) : SW'(2));
   assign post_last = is_reset ? SW'(0) : SW'(1);

   // Successor TCK period and the pin values it drives, applied on the TCK falling edge.
   always_comb begin
      nxt_state = state;
      nxt_step  = step + SW'(1);
      case (state)
         PRE:
            if (step == pre_last) begin
               nxt_state = is_reset ? POST : SHIFT;
               nxt_step  = '0;
            end
         SHIFT:
            if (step == len_ext) begin
               nxt_state = POST;
               nxt_step  = '0;
            end
         POST:
            if (step == post_last) begin
               nxt_state = is_reset ? IDLE : RESP;
               nxt_step  = '0;
            end
         default: ;
      endcase

      nxt_tms  = 1'b0;
      nxt_tdi  = 1'b0;
      nxt_trst = 1'b1;
      case (nxt_state)
         PRE: begin
            nxt_trst = ~is_reset;
            nxt_tms  = is_reset | (nxt_step == '0) | ((op_r == OP_IR) && (nxt_step == SW'(1)));
         end
         SHIFT: begin
            nxt_tms = (nxt_step == len_ext);
            nxt_tdi = data_r[nxt_step[LEN_W-1:0]];
         end
         POST:    nxt_tms = ~is_reset & (nxt_step == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_r      <= OP_RESET;
         len_r     <= '0;
         data_r    <= '0;
         step      <= '0;
         div_cnt   <= '0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         trst      <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               trst      <= 1'b1;
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  op_r      <= (cmd_op == 2'd3) ? OP_RESET : op_t'(cmd_op);
                  len_r     <= cmd_len;
                  data_r    <= cmd_data;
                  rsp_data  <= '0;
                  state     <= PRE;
                  step      <= '0;
                  div_cnt   <= '0;
                  tms       <= 1'b1;
                  tdi       <= 1'b0;
                  trst      <= (cmd_op == 2'd1) || (cmd_op == 2'd2);
                  cmd_ready <= 1'b0;
               end
            end
            PRE, SHIFT, POST: begin
               if (!tick) begin
                  div_cnt <= div_cnt + CW'(1);
               end else begin
                  div_cnt <= '0;
                  if (!tck) begin
                     tck <= 1'b1;
                     if (state == SHIFT) rsp_data[step[LEN_W-1:0]] <= tdo;
                  end else begin
                     tck       <= 1'b0;
                     state     <= nxt_state;
                     step      <= nxt_step;
                     tms       <= nxt_tms;
                     tdi       <= nxt_tdi;
                     trst      <= nxt_trst;
                     rsp_valid <= (nxt_state == RESP);
                     cmd_ready <= (nxt_state == IDLE);
                  end
               end
            end
            RESP:
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host: table of commands with a TCK-period pin log,
// a tdo target model and a response scoreboard, plus back-pressure and mid-scan reset.
module tb_jtag_host;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 32;
   localparam int LEN_W   = 5;

   logic               clk = 1'b0;
   logic               rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0]         cmd_op;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data, rsp_data;
   logic               tck, tms, tdi, trst, tdo;

   always #5 clk = ~clk;

   jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
   );

   typedef struct {
      logic [1:0]       op;
      logic [LEN_W-1:0] len;
      logic [31:0]      data;
      bit               pat;   // 1: tdo = 1 only in period 4, 0: tdo = tdi delayed one TCK
      logic [31:0]      exp;
   } vec_t;

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] sb[$];
   int          cyc = 0, acc_cyc = 0, rsp_cyc = 0, ready_cyc = 0, per_cnt = 0;
   bit          rsp_seen = 0, tck_prev = 0, last_tdi = 0, tdo_pat = 0;
   logic [1:0]  cur_op = '0;
   logic [31:0] cur_exp = '0;
   logic [63:0] tms_log = '0, tdi_log = '0, trst_log = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out / unexpected event", name);
   endtask

   // Pin log per TCK period, target tdo model, acceptance tracking and scoreboard pop.
   always @(negedge clk) begin
      cyc++;
      if (tck && !tck_prev) begin
         if (per_cnt < 64) begin
            tms_log[per_cnt]  = tms;
            tdi_log[per_cnt]  = tdi;
            trst_log[per_cnt] = trst;
         end
         per_cnt++;
         last_tdi = tdi;
      end
      if (!tck && tck_prev) tdo = tdo_pat ? (per_cnt == 4) : last_tdi;
      tck_prev = tck;
      if (cmd_ready && ready_cyc < 0) ready_cyc = cyc;
      if (rsp_valid && !rsp_seen) begin
         rsp_seen = 1;
         rsp_cyc  = cyc;
      end
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) note_fail("unexpected_rsp");
         else chk("rsp_data", rsp_data, sb.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
         acc_cyc   = cyc;
         ready_cyc = -1;
         per_cnt   = 0;
         tms_log   = '0;
         tdi_log   = '0;
         trst_log  = '0;
         last_tdi  = 0;
         tdo       = 1'b0;
         rsp_seen  = 0;
         if (cur_op == 2'd1 || cur_op == 2'd2) sb.push_back(cur_exp);
      end
   end

   // Expected pin sequence per TCK period: bit p of each vector belongs to period p.
   function automatic void build(input vec_t v, output logic [63:0] et, output logic [63:0] ed,
                                 output logic [63:0] er, output int np);
      int p = 0;
      et = '0;
      ed = '0;
      er = '1;
      if (v.op == 2'd1 || v.op == 2'd2) begin
         et[p] = 1'b1; p++;
         if (v.op == 2'd1) begin et[p] = 1'b1; p++; end
         p += 2;
         for (int k = 0; k <= int'(v.len); k++) begin
            ed[p] = v.data[k];
            et[p] = (k == int'(v.len));
            p++;
         end
         et[p] = 1'b1; p++;
         p++;
      end else begin
         for (int k = 0; k < 5; k++) begin
            et[p] = 1'b1;
            er[p] = 1'b0;
            p++;
         end
         p++;
      end
      np = p;
   endfunction

   task automatic issue(input vec_t v);
      int g = 0;
      while (!cmd_ready && g < 500) begin @(posedge clk); #1; g++; end
      if (!cmd_ready) note_fail("issue_ready");
      cur_op  = v.op;
      cur_exp = v.exp;
      tdo_pat = v.pat;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_len   = v.len;
      cmd_data  = v.data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic finish_vec(input vec_t v, input string name);
      int          g = 0;
      int          np;
      logic [63:0] et, ed, er, m;
      while (!(cmd_ready && sb.size() == 0) && g < 2000) begin @(posedge clk); #1; g++; end
      if (g >= 2000) begin
         note_fail({name, "_done"});
         return;
      end
      @(negedge clk); #1;
      build(v, et, ed, er, np);
      m = (64'd1 << np) - 64'd1;
      chk({name, "_periods"}, 64'(per_cnt), 64'(np));
      chk({name, "_tms"}, tms_log & m, et & m);
      chk({name, "_tdi"}, tdi_log & m, ed & m);
      chk({name, "_trst"}, trst_log & m, er & m);
      if (v.op == 2'd0 || v.op == 2'd3) begin
         chk({name, "_ready_lat"}, 64'(ready_cyc - acc_cyc), 64'(6 * 2 * CLK_DIV + 1));
         chk({name, "_no_rsp"}, 64'(rsp_seen), 64'd0);
      end
      if (v.op == 2'd2 && v.len == 5'd31)
         chk({name, "_rsp_lat"}, 64'(rsp_cyc - acc_cyc), 64'(37 * 4 + 1));
   endtask

   task automatic run_vec(input vec_t v, input string name);
      issue(v);
      finish_vec(v, name);
   endtask

   vec_t vecs[8];
   vec_t bp_v, rst_v, mid_v;
   logic [31:0] held;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{op: 2'd0, len: 5'd0,  data: 32'h0,         pat: 0, exp: 32'h0};
      vecs[1] = '{op: 2'd1, len: 5'd3,  data: 32'hA,         pat: 1, exp: 32'h1};
      vecs[2] = '{op: 2'd2, len: 5'd31, data: 32'hA5A5_0F0F, pat: 0, exp: 32'h4B4A_1E1E};
      vecs[3] = '{op: 2'd2, len: 5'd0,  data: 32'h1,         pat: 0, exp: 32'h0};
      vecs[4] = '{op: 2'd2, len: 5'd7,  data: 32'hFFFF_FF3C, pat: 0, exp: 32'h78};
      vecs[5] = '{op: 2'd1, len: 5'd4,  data: 32'h16,        pat: 0, exp: 32'h0C};
      vecs[6] = '{op: 2'd3, len: 5'd9,  data: 32'hFFFF_FFFF, pat: 0, exp: 32'h0};
      vecs[7] = '{op: 2'd2, len: 5'd15, data: 32'h1234,      pat: 0, exp: 32'h2468};
      bp_v    = '{op: 2'd2, len: 5'd7,  data: 32'h5A,        pat: 0, exp: 32'hB4};
      rst_v   = '{op: 2'd0, len: 5'd0,  data: 32'h0,         pat: 0, exp: 32'h0};
      mid_v   = '{op: 2'd2, len: 5'd15, data: 32'hBEEF,      pat: 0, exp: 32'h0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
      rsp_ready = 1'b1; tdo = 1'b0;

      // Reset release
      @(negedge clk);
      chk("reset_pins", {tck, tms, tdi, trst, cmd_ready, rsp_valid}, 6'b010000);
      chk("reset_rsp_data", rsp_data, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("release_trst_low", {trst, cmd_ready}, 2'b00);
      @(negedge clk);
      chk("release_ready", {tck, tms, trst, cmd_ready}, 4'b0111);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-pressure, then rsp_ready together with a new command
      rsp_ready = 1'b0;
      issue(bp_v);
      begin
         int g = 0;
         while (!rsp_valid && g < 500) begin @(posedge clk); #1; g++; end
         if (!rsp_valid) note_fail("bp_rsp_wait");
      end
      held = rsp_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", {rsp_valid, cmd_ready, tck, rsp_data}, {3'b100, held});
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      cur_op    = 2'd0;
      tdo_pat   = 0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_len   = '0;
      cmd_data  = '0;
      @(negedge clk);
      chk("bp_same_cycle_not_ready", cmd_ready, 1'b0);
      @(negedge clk);
      chk("bp_ready_next", {cmd_ready, rsp_valid}, 2'b10);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      finish_vec(rst_v, "bp_reset");

      // Reset in the middle of a 16-bit DR shift
      issue(mid_v);
      begin
         int g = 0;
         while (per_cnt < 8 && g < 500) begin @(posedge clk); #1; g++; end
         if (per_cnt < 8) note_fail("mid_wait");
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_pins", {tck, tms, tdi, trst, cmd_ready, rsp_valid}, 6'b010000);
      chk("mid_reset_rsp_data", rsp_data, 32'h0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("mid_no_rsp", {rsp_seen, rsp_valid}, 2'b00);
      run_vec(rst_v, "after_mid_reset");
      run_vec(vecs[1], "after_mid_ir");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
